// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and
// the sequencing FSM states.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign-corrected at the end.
//
//  state  | meaning
//  -------+-----------------------------------------------------------------
//  S_IDLE | waiting for start; MTHI/MTLO write hi/lo directly
//  S_RUN  | cnt 0..N-1: one iteration per cycle; cnt==N: sign-correct, write
//  S_DONE | one-cycle done pulse, starts ignored, then back to S_IDLE
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [2:0]   op,
   input  logic         start,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(N + 1);

   state_e          state_q, state_d;
   logic [2*N-1:0]  acc_q, acc_d;
   logic [N-1:0]    opd_q, opd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            is_div_q, is_div_d;
   logic            neg_q, neg_d;
   logic            rneg_q, rneg_d;
   logic [N-1:0]    hi_q, hi_d;
   logic [N-1:0]    lo_q, lo_d;

   op_e             op_cmd;
   logic            signed_op, div_op, a_neg, b_neg;
   logic [N-1:0]    a_mag, b_mag;
   logic [N:0]      add_x, add_y, add_s;
   logic [2*N-1:0]  mul_step, div_step, prod_f;
   logic [N-1:0]    quo_f, rem_f;

   assign op_cmd    = op_e'(op);
   assign signed_op = (op_cmd == OP_MULT) || (op_cmd == OP_DIV);
   assign div_op    = (op_cmd == OP_DIV) || (op_cmd == OP_DIVU);
   assign a_neg     = signed_op & a[N-1];
   assign b_neg     = signed_op & b[N-1];
   assign a_mag     = a_neg ? -a : a;
   assign b_mag     = b_neg ? -b : b;

   // Single N+1-bit adder: multiply adds the multiplicand into the upper half,
   // divide subtracts the divisor from the shifted partial remainder.
   assign add_x = is_div_q ? acc_q[2*N-1:N-1] : {1'b0, acc_q[2*N-1:N]};
   assign add_y = is_div_q ? ~{1'b0, opd_q} : {1'b0, opd_q};
   assign add_s = add_x + add_y + {{N{1'b0}}, is_div_q};

   assign mul_step = acc_q[0] ? {add_s, acc_q[N-1:1]} : {1'b0, acc_q[2*N-1:1]};
   // Partial remainder stays below the divisor, so add_s[N] is a true sign bit.
   assign div_step = add_s[N] ? {acc_q[2*N-2:0], 1'b0}
                              : {add_s[N-1:0], acc_q[N-2:0], 1'b1};

   assign prod_f = neg_q  ? -acc_q : acc_q;
   assign quo_f  = neg_q  ? -acc_q[N-1:0] : acc_q[N-1:0];
   assign rem_f  = rneg_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op_cmd)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     is_div_d = div_op;
                     acc_d    = {{N{1'b0}}, (div_op ? a_mag : b_mag)};
                     opd_d    = div_op ? b_mag : a_mag;
                     // A zero divisor leaves quotient all ones and remainder |a|,
                     // so only the remainder sign fix is needed to return a.
                     neg_d    = (a_neg ^ b_neg) & ~(div_op && (b == '0));
                     rneg_d   = div_op & a_neg;
                     cnt_d    = '0;
                     state_d  = S_RUN;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (cnt_q == CW'(N)) begin
               if (is_div_q) begin
                  hi_d = rem_f;
                  lo_d = quo_f;
               end else begin
                  hi_d = prod_f[2*N-1:N];
                  lo_d = prod_f[N-1:0];
               end
               state_d = S_DONE;
            end else begin
               acc_d = is_div_q ? div_step : mul_step;
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         opd_q    <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);

endmodule
